// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, grant owners and
// a small helper that names the opposite service state.
package dmem_arb_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CPU  = 2'd1;
  localparam logic [1:0] S_DBG  = 2'd2;

  localparam logic G_CPU = 1'b0;
  localparam logic G_DBG = 1'b1;

  function automatic logic [1:0] other_state(input logic [1:0] s);
    return (s == S_CPU) ? S_DBG : S_CPU;
  endfunction

endpackage

// File: rtl/dmem_arb_mux.sv
// Combinational owner select: routes the serving requester onto the memory
// bank and steers ack/rdata back to it; everything is zero when nobody owns it.
module dmem_arb_mux #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          sel_cpu_i,
  input  logic          sel_dbg_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          dbg_ack_o,
  output logic [DW-1:0] dbg_rdata_o
);

  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    cpu_ack_o   = 1'b0;
    cpu_rdata_o = '0;
    dbg_ack_o   = 1'b0;
    dbg_rdata_o = '0;
    if (sel_cpu_i) begin
      mem_read_o  = cpu_req_i & ~cpu_we_i;
      mem_write_o = cpu_req_i & cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      cpu_ack_o   = cpu_req_i;
      cpu_rdata_o = mem_rdata_i;
    end else if (sel_dbg_i) begin
      mem_read_o  = dbg_req_i & ~dbg_we_i;
      mem_write_o = dbg_req_i & dbg_we_i;
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
      dbg_ack_o   = dbg_req_i;
      dbg_rdata_o = mem_rdata_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store path and the debug port, with a bounded hold and a debug lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 4,
  parameter int CW       = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          own_req, oth_req, at_limit;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    hold_d   = '0;
    own_req  = 1'b0;
    oth_req  = 1'b0;
    at_limit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req && dbg_req) state_d = (last_q == G_DBG) ? S_CPU : S_DBG;
        else if (cpu_req)       state_d = S_CPU;
        else if (dbg_req)       state_d = S_DBG;
      end
      S_CPU, S_DBG: begin
        own_req  = (state_q == S_CPU) ? cpu_req : dbg_req;
        oth_req  = (state_q == S_CPU) ? dbg_req : cpu_req;
        // A locked debug owner keeps counting but is never forced off.
        at_limit = own_req && oth_req && (hold_q == HOLD_LIM) &&
                   !((state_q == S_DBG) && dbg_lock);
        if (!own_req)      state_d = oth_req ? other_state(state_q) : S_IDLE;
        else if (at_limit) state_d = other_state(state_q);
        if ((state_d == state_q) && own_req && oth_req)
          hold_d = (hold_q == HOLD_LIM) ? hold_q : hold_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_CPU && state_q != S_CPU) last_d = G_CPU;
    if (state_d == S_DBG && state_q != S_DBG) last_d = G_DBG;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      last_q  <= G_DBG;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  dmem_arb_mux #(.AW(AW), .DW(DW)) u_mux (
    .sel_cpu_i   (state_q == S_CPU),
    .sel_dbg_i   (state_q == S_DBG),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .dbg_req_i   (dbg_req),
    .dbg_we_i    (dbg_we),
    .dbg_addr_i  (dbg_addr),
    .dbg_wdata_i (dbg_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cpu_ack_o   (cpu_ack),
    .cpu_rdata_o (cpu_rdata),
    .dbg_ack_o   (dbg_ack),
    .dbg_rdata_o (dbg_rdata)
  );

  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs change 1ns after the rising edge,
// outputs are checked on the falling edge against hand-computed values.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock, dbg_ack;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(4), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
    mem_rdata = 32'h1111_2222;
    repeat (2) next_cyc();

    // Store requested while reset is held low
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h1234;
    @(negedge clk);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_cpu_ack",   {31'b0, cpu_ack},   32'd0);
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rst_mem_addr",  mem_addr,           32'd0);
    reset = 1'b1;
    next_cyc(); @(negedge clk);
    chk("rel_cpu_ack",   {31'b0, cpu_ack},   32'd1);
    chk("rel_mem_write", {31'b0, mem_write}, 32'd1);
    chk("rel_mem_addr",  mem_addr,           32'h44);
    chk("rel_mem_wdata", mem_wdata,          32'h1234);
    chk("rel_cpu_stall", {31'b0, cpu_stall}, 32'd0);

    // Drop request, return to IDLE, then a load from IDLE
    next_cyc(); cpu_req = 0; @(negedge clk);
    chk("drop_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    next_cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_idle_stall", {31'b0, cpu_stall}, 32'd1);
    chk("ld_idle_ack",   {31'b0, cpu_ack},   32'd0);
    chk("ld_idle_read",  {31'b0, mem_read},  32'd0);
    next_cyc(); @(negedge clk);
    chk("ld_ack",       {31'b0, cpu_ack},   32'd1);
    chk("ld_rdata",     cpu_rdata,          32'hDEADBEEF);
    chk("ld_read",      {31'b0, mem_read},  32'd1);
    chk("ld_addr",      mem_addr,           32'h10);
    chk("ld_stall",     {31'b0, cpu_stall}, 32'd0);
    chk("ld_dbg_rdata", dbg_rdata,          32'd0);
    next_cyc(); cpu_addr = 32'h14; mem_rdata = 32'hCAFEF00D; @(negedge clk);
    chk("ld2_ack",   {31'b0, cpu_ack}, 32'd1);
    chk("ld2_rdata", cpu_rdata,        32'hCAFEF00D);
    next_cyc(); cpu_req = 0;
    next_cyc();

    // Reset pulse, then both request together: CPU first, 4/4 alternation
    reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'hA5A5;
    @(negedge clk);
    chk("tie_rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    chk("tie_rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      next_cyc(); @(negedge clk);
      chk($sformatf("tie_cpu_ack_c%0d", i), {31'b0, cpu_ack},
          (((i - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("tie_dbg_ack_c%0d", i), {31'b0, dbg_ack},
          (((i - 1) / 4) % 2 == 1) ? 32'd1 : 32'd0);
      if (i == 5) begin
        chk("tie_dbg_write", {31'b0, mem_write}, 32'd1);
        chk("tie_dbg_addr",  mem_addr,           32'h20);
        chk("tie_dbg_stall", {31'b0, cpu_stall}, 32'd1);
        chk("tie_cpu_rdata", cpu_rdata,          32'd0);
      end
    end

    // Debug owns again; with lock held it keeps the bank for 10 cycles
    for (int k = 0; k < 10; k++) begin
      next_cyc();
      if (k == 0) dbg_lock = 1;
      @(negedge clk);
      chk($sformatf("lock_dbg_ack_%0d", k), {31'b0, dbg_ack}, 32'd1);
      chk($sformatf("lock_stall_%0d", k),   {31'b0, cpu_stall}, 32'd1);
    end
    next_cyc(); dbg_lock = 0; @(negedge clk);
    chk("unlock_dbg_ack", {31'b0, dbg_ack}, 32'd1);
    next_cyc(); @(negedge clk);
    chk("unlock_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    chk("unlock_dbg_off", {31'b0, dbg_ack}, 32'd0);

    // CPU drops while debug waits: direct handover
    next_cyc(); cpu_req = 0; @(negedge clk);
    chk("hand_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    chk("hand_dbg_wait", {31'b0, dbg_ack}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("hand_dbg_ack",   {31'b0, dbg_ack},   32'd1);
    chk("hand_mem_write", {31'b0, mem_write}, 32'd1);
    chk("hand_mem_addr",  mem_addr,           32'h20);

    // Reset during the debug write: strobe drops immediately
    reset = 1'b0;
    #1;
    chk("mrst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("mrst_dbg_ack",   {31'b0, dbg_ack},   32'd0);
    chk("mrst_mem_addr",  mem_addr,           32'd0);
    next_cyc(); @(negedge clk);
    chk("mrst_hold_write", {31'b0, mem_write}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mrst_rel_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    next_cyc(); @(negedge clk);
    chk("mrst_after_dbg_ack", {31'b0, dbg_ack}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory bank between the processor load/store path and a debug/loader port.
- Arbitration: round-robin with a bounded hold count, plus a debug lock.
- Drives the processor stall so the PC freezes while a processor access waits.
- Sits between the processor datapath (ALU address, register read data, mem_read/mem_write from control) and the data memory bank.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_HOLD, 4, max consecutive grants to one owner while the other requester waits (>=1)
- CW, 3, width of the hold counter; must satisfy 2**CW >= MAX_HOLD

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  processor access request (mem_read | mem_write from control)
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  AW  ALU result address
- cpu_wdata  in  DW  store data
- cpu_ack  out  1  access performed this cycle
- cpu_rdata  out  DW  load data, valid when cpu_ack & ~cpu_we
- cpu_stall  out  1  cpu_req & ~cpu_ack; freezes PC/register write
- dbg_req  in  1  debug request
- dbg_we  in  1  debug write enable
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_lock  in  1  suppresses MAX_HOLD forced switch while debug owns the memory
- dbg_ack  out  1  debug access performed this cycle
- dbg_rdata  out  DW  debug read data, valid when dbg_ack & ~dbg_we
- mem_read  out  1  to memory bank
- mem_write  out  1  to memory bank
- mem_addr  out  AW  to memory bank
- mem_wdata  out  DW  to memory bank
- mem_rdata  in  DW  combinational read data from memory bank

Behaviour:
- Registered state: FSM {IDLE, SERVE_CPU, SERVE_DBG}; last_grant (CPU/DBG); hold_cnt[CW-1:0].
- Reset (reset=0, async) forces: state=IDLE, last_grant=DBG (CPU wins the first tie), hold_cnt=0.
- Outputs are combinational from state, so all acks, mem_read, mem_write, mem_addr and mem_wdata are 0 immediately on reset assertion.
- An access in flight when reset asserts is aborted; no write may occur while reset is low.
- Request protocol:
  - Requester holds req/we/addr/wdata stable until ack.
  - Ack is a single-cycle completion. The next transaction may be presented in the following cycle.
- IDLE:
  - No memory strobe; acks = 0; mem_addr/mem_wdata = 0.
  - Next state: both req -> serve the requester opposite last_grant; one req -> serve it; none -> IDLE.
  - Arbitration latency is 1 cycle: a request first seen in IDLE is acked in the next cycle.
- SERVE_X (X = owner, Y = other):
  - mem_addr/mem_wdata = X signals; mem_read = X_req & ~X_we; mem_write = X_req & X_we; X_ack = X_req; Y_ack = 0.
  - X_rdata = mem_rdata. Non-owner rdata = 0.
  - On entry, last_grant <= X.
  - hold_cnt increments on each X_ack while Y_req=1; it clears on a state change or when Y_req=0.
  - Next state:
    - X_req=0 -> SERVE_Y if Y_req, else IDLE.
    - X_req & Y_req & hold_cnt==MAX_HOLD-1 -> SERVE_Y. Does not apply when X=DBG and dbg_lock=1.
    - Otherwise stay.
  - Switch from SERVE_X to SERVE_Y is direct, with no IDLE bubble.
- Back-to-back requests from the owner are acked every cycle (throughput 1/cycle) until a forced switch.
- cpu_stall is combinational: high in IDLE when cpu_req=1, and in SERVE_DBG when cpu_req=1.
- dbg_lock deasserting mid-burst: the limit check resumes on the next cycle using the current hold_cnt. If hold_cnt >= MAX_HOLD-1, the arbiter switches at the next ack.
- Owner drops req in the same cycle Y raises req: Y is served next cycle (1 cycle latency).
- Simultaneous first requests after reset: CPU is served first, DBG second.
- Widths: hold_cnt saturates at MAX_HOLD-1 and never wraps. No address/data arithmetic is performed.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_CPU=2'd1, S_DBG=2'd2;
  - grant encoding G_CPU=1'b0, G_DBG=1'b1.
- One natural sub-module: dmem_arb_mux, the combinational owner-select of addr/wdata/strobes and the rdata/ack steering.
- FSM and hold counter stay in the top.

Test Plan:
- Reset: hold reset=0 with cpu_req=1, cpu_we=1 -> mem_write=0, cpu_ack=0, cpu_stall=1. Release -> cycle 1 cpu_ack=1, mem_write=1, mem_addr=cpu_addr.
- Single CPU load: cpu_req=1, cpu_we=0, addr=0x10, mem_rdata=0xDEADBEEF from IDLE -> stall for 1 cycle, then cpu_ack=1, cpu_rdata=0xDEADBEEF. Continued loads are acked every cycle.
- Tie after reset: both req in IDLE -> SERVE_CPU first. With both held, exactly 4 cpu_acks, then 4 dbg_acks, alternating (MAX_HOLD=4).
- Debug lock: dbg_lock=1 with dbg_req and cpu_req held for 10 cycles in SERVE_DBG -> 10 consecutive dbg_acks, cpu_stall=1 throughout. Drop lock at hold_cnt=3 -> switch to CPU after the next dbg_ack.
- Mid-burst reset: assert reset during a DBG write at addr 0x20 -> mem_write drops the same cycle (async). After release, the FSM is in IDLE and no ack occurs in the release cycle.
- Handover without bubble: CPU drops req while dbg_req=1 -> next cycle dbg_ack=1, with no IDLE cycle in between.
